gray_wptr_gen: RTL
==================

# gray_wptr_gen

Write-side pointer generator for a dual-clock FIFO. It keeps a binary write counter, publishes the write pointer Gray-coded and registered for crossing into the read domain, and derives full, almost-full and overflow flags. The read pointer arrives Gray-coded from the read domain and is converted back to binary internally for the level computation. It is the encoding counterpart of the read-side Gray-to-binary address decoder.

## Interface
- `WIDTH`, default 8: FIFO address bits. Depth is 2^WIDTH. Pointers are WIDTH+1 bits. Legal values: WIDTH ≥ 2.
- `AF_LEVEL`, default 2^WIDTH-2: almost-full threshold, in entries. Legal range: 1..2^WIDTH.

Ports:
- `sys_clk`  in  1: system clock. All logic runs on the rising edge.
- `sys_rst_n`  in  1: reset, synchronous, active-low.
- `inc`  in  1: write request for one entry.
- `rptr_gray`  in  WIDTH+1: read pointer, Gray-coded, from the read domain.
- `waddr`  out  WIDTH: RAM write address, equal to `wbin[WIDTH-1:0]`.
- `wptr_gray`  out  WIDTH+1: registered Gray write pointer.
- `full`  out  1: registered full flag.
- `almost_full`  out  1: registered flag, high when level ≥ `AF_LEVEL`.
- `accept`  out  1: combinational, `inc & ~full`. This is the RAM write enable.
- `ovf`  out  1: registered one-cycle pulse for an `inc` issued while full.

## Operation
- **Internal state:** `wbin` [WIDTH:0].
- **Next-pointer computation:**
  - `wbin_next = wbin + accept`, modulo 2^(WIDTH+1), so it wraps from all-ones to 0.
  - `wgray_next = wbin_next ^ (wbin_next >> 1)`.
- **Register updates on each edge:**
  - `wbin <= wbin_next`.
  - `wptr_gray <= wgray_next`.
  - `waddr` follows `wbin`.
- **Read pointer input:** `rptr_s` is `rptr_gray`, or its synchronized copy (see Configuration). `rbin` is the Gray-to-binary conversion of `rptr_s`: `rbin[i] = ^rptr_s[WIDTH:i]`.
- **Full:** `full <= (wgray_next == {~rptr_s[WIDTH:WIDTH-1], rptr_s[WIDTH-2:0]})`.
- **Level:** `level = wbin_next - rbin`, computed WIDTH+1 bits wide, modulo. The range is 0..2^WIDTH.
- **Almost-full:** `almost_full <= (level >= AF_LEVEL)`.
- **Overflow:** `ovf <= inc & full`. `full` is never bypassed, so the pointer must not advance while full.
- **Gray property:** `wptr_gray` changes exactly one bit per accepted write, including at wrap-around.
- **Reset:** while `sys_rst_n` = 0 at an edge, the following are cleared to 0 regardless of `inc`:
  - `wbin`, `wptr_gray`, `waddr`, `full`, `almost_full`, `ovf`, and the synchronizer stages.
  - `accept` may be high during reset cycles, but no pointer advance occurs.
- **Simultaneous write and read-pointer change:** both take effect in the same flag evaluation. Flags always reflect the post-edge `wbin` against the current `rptr_s`.

## Timing
- **Write latency:** an `accept` sampled at edge k produces new `waddr` and `wptr_gray` values visible after edge k.
- **Flag latency on writes:** `full` and `almost_full` reflect the write accepted at edge k, also after edge k. A write that fills the FIFO raises `full` at that same edge, so a following `inc` is refused.
- **Flag latency on read-pointer changes:**
  - Without the macro: a change on `rptr_gray` deasserts `full` one edge later.
  - With the macro: two additional edges of latency.
- **`ovf` timing:** `ovf` goes high one cycle after the refused `inc`, for one cycle per refused request.
- **Release values:** after reset release, the first `accept` is honored at the first edge with `sys_rst_n` = 1.

## Configuration
- `GRAY_WPTR_SYNC_EN`
  - **Defined:** `rptr_gray` passes through an internal two-flop synchronizer clocked by `sys_clk`, reset to 0, and `rptr_s` is the second stage. Read-pointer-driven flag updates take 3 edges.
  - **Undefined:** `rptr_s = rptr_gray` directly, and the caller supplies an already synchronized pointer. Flag updates take 1 edge.

## Test plan
All scenarios use WIDTH=3 (depth 8), AF_LEVEL=6, macro undefined unless stated.
1. **Reset:** hold `sys_rst_n`=0 with `inc`=1 for 3 cycles → `wptr_gray`=4'b0000, `waddr`=0, and `full`, `almost_full`, `ovf` all 0.
2. **Fill:** `rptr_gray`=0, then 8 consecutive `inc` → `wptr_gray` steps 1,3,2,6,7,5,4,C (hex). `almost_full` rises after the 6th accept. `full` rises after the 8th, with `wptr_gray`=4'b1100.
3. **Overflow:** while full, `inc`=1 for 2 cycles → `accept`=0, `wptr_gray` holds at 4'b1100, and `ovf` is high for 2 cycles, each lagging its request by one.
4. **Drain by one:** `rptr_gray` → 4'b0001 → `full` drops one edge later and `almost_full` stays 1. Then one `inc` → accepted, `wptr_gray`=4'b1101, and `full` returns to 1.
5. **Wrap:** the read pointer tracks the write pointer (level ≤ 4) over 20 accepts → `wbin` wraps 15→0 with `wptr_gray` 4'b1000→4'b0000. Every transition is a single-bit change, and `full` never asserts.
6. **Mid-stream reset and macro latency:**
   - Reset mid-stream: assert reset at `wbin`=5 with `inc`=1 → all outputs 0 after the edge.
   - Macro latency: with `GRAY_WPTR_SYNC_EN`, repeat scenario 4 → `full` drops 3 edges after the `rptr_gray` change.

Source files
------------

// File: rtl/gray_wptr_gen_if.sv
// Bundle between the FIFO write client and the Gray write-pointer generator.
// The client drives the request and the read pointer; the generator returns the address, the pointer and the flags.
interface gray_wptr_gen_if #(
    parameter int WIDTH = 8
);
    logic             inc;
    logic [WIDTH:0]   rptr_gray;
    logic [WIDTH-1:0] waddr;
    logic [WIDTH:0]   wptr_gray;
    logic             full;
    logic             almost_full;
    logic             accept;
    logic             ovf;

    modport master (
        output inc, rptr_gray,
        input  waddr, wptr_gray, full, almost_full, accept, ovf
    );

    modport slave (
        input  inc, rptr_gray,
        output waddr, wptr_gray, full, almost_full, accept, ovf
    );
endinterface

// File: rtl/gray_wptr_gen.sv
// Write-side pointer generator for a dual-clock FIFO: binary write counter, registered Gray pointer, full/almost-full/overflow flags.
// Optional macro GRAY_WPTR_SYNC_EN inserts a two-flop synchronizer on the incoming Gray read pointer.
module gray_wptr_gen #(
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = (1 << WIDTH) - 2
) (
    input logic            sys_clk,
    input logic            sys_rst_n,
    gray_wptr_gen_if.slave bus
);

    localparam logic [WIDTH:0] AF_LEVEL_C = (WIDTH+1)'(AF_LEVEL);

    function automatic logic [WIDTH:0] bin2gray(input logic [WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH:0] gray2bin(input logic [WIDTH:0] g);
        logic [WIDTH:0] b;
        b[WIDTH] = g[WIDTH];
        for (int i = WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH:0] wbin_r;
    logic [WIDTH:0] wptr_gray_r;
    logic           full_r;
    logic           almost_full_r;
    logic           ovf_r;

    logic           accept_s;
    logic [WIDTH:0] wbin_next_s;
    logic [WIDTH:0] wgray_next_s;
    logic [WIDTH:0] rptr_s;
    logic [WIDTH:0] rbin_s;
    logic [WIDTH:0] level_s;
    logic           full_next_s;
    logic           almost_full_next_s;

`ifdef GRAY_WPTR_SYNC_EN
    logic [WIDTH:0] rptr_sync1_r;
    logic [WIDTH:0] rptr_sync2_r;

    // Two-flop synchronizer for the read pointer arriving from the read domain.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rptr_sync1_r <= {(WIDTH+1){1'b0}};
            rptr_sync2_r <= {(WIDTH+1){1'b0}};
        end else begin
            rptr_sync1_r <= bus.rptr_gray;
            rptr_sync2_r <= rptr_sync1_r;
        end
    end

    assign rptr_s = rptr_sync2_r;
`else
    assign rptr_s = bus.rptr_gray;
`endif

    // Next pointer and flag evaluation; flags look at the post-edge pointer against the current read pointer.
    always_comb begin
        accept_s           = bus.inc & ~full_r;
        wbin_next_s        = wbin_r + {{WIDTH{1'b0}}, accept_s};
        wgray_next_s       = bin2gray(wbin_next_s);
        rbin_s             = gray2bin(rptr_s);
        level_s            = wbin_next_s - rbin_s;
        // Full when the Gray pointers differ only in their top two bits (one lap ahead).
        full_next_s        = (wgray_next_s == {~rptr_s[WIDTH:WIDTH-1], rptr_s[WIDTH-2:0]});
        almost_full_next_s = (level_s >= AF_LEVEL_C);
    end

    // Pointer and flag registers.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wbin_r        <= {(WIDTH+1){1'b0}};
            wptr_gray_r   <= {(WIDTH+1){1'b0}};
            full_r        <= 1'b0;
            almost_full_r <= 1'b0;
            ovf_r         <= 1'b0;
        end else begin
            wbin_r        <= wbin_next_s;
            wptr_gray_r   <= wgray_next_s;
            full_r        <= full_next_s;
            almost_full_r <= almost_full_next_s;
            ovf_r         <= bus.inc & full_r;
        end
    end

    assign bus.accept      = accept_s;
    assign bus.waddr       = wbin_r[WIDTH-1:0];
    assign bus.wptr_gray   = wptr_gray_r;
    assign bus.full        = full_r;
    assign bus.almost_full = almost_full_r;
    assign bus.ovf         = ovf_r;

endmodule
